ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
- Programming-side master for the fabric configuration chains: accepts a bitstream as a valid/ready stream of NUM_CHAINS-bit words and shifts one bit per chain into ccff_head on each prog_clk pulse.
- Sequences pReset, config_enable and IO_ISOL_N around the load, then releases the fabric into user mode with all globals in their operating values.
- Sits between the SoC bitstream source (DMA/FIFO) and fpga_top's programming ports.

Parameters:
- NUM_CHAINS, 12, number of parallel configuration chains (ccff_head width).
- CHAIN_LEN, 1024, bits per chain; words accepted per load.
- PRESET_CYCLES, 8, clk cycles pReset is held asserted (low) before shifting; must be >= 1.
- TIMEOUT_CYCLES, 4096, stall limit; used only with CCFF_LOAD_WATCHDOG_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request; honoured only in IDLE.
- bs_data  in  NUM_CHAINS  bitstream word; bit i goes to chain i.
- bs_valid  in  1  bs_data valid.
- bs_ready  out  1  loader accepts word this cycle.
- prog_clk  out  1  registered programming clock to the fabric.
- ccff_head  out  NUM_CHAINS  registered chain heads.
- pReset  out  1  configuration reset, active-low.
- config_enable  out  1  high while the fabric is being configured.
- IO_ISOL_N  out  1  IO isolation, active-low (0 = isolated).
- busy  out  1  high in any state other than IDLE.
- done  out  1  high after a completed load until the next accepted start or reset.
- err  out  1  watchdog timeout flag; constant 0 without the macro.

Behaviour:
- Reset values: bs_ready=0, prog_clk=0, ccff_head=0, pReset=1, config_enable=0, IO_ISOL_N=1, busy=0, done=0, err=0, state=IDLE, bit counter=0.
- All outputs are registered except bs_ready, which is decoded from state (state==LOAD).
- IDLE: start=1 -> PRESET. Same edge: pReset<=0, config_enable<=1, IO_ISOL_N<=0, done<=0, preset counter<=0.
- PRESET: stays PRESET_CYCLES cycles, then pReset<=1 and state -> LOAD.
- LOAD: bs_ready=1. On bs_valid&bs_ready: ccff_head<=bs_data, bit counter++, state -> SETUP.
- SETUP: prog_clk<=1, state -> PULSE. This gives one full clk of data setup before the fabric-side rising edge.
- PULSE: prog_clk<=0. If bit counter==CHAIN_LEN -> FINISH, else -> LOAD.
- Shift rate: max one bit per 3 clk cycles. ccff_head is stable from the handshake edge until the next handshake.
- FINISH (1 cycle): config_enable<=0, IO_ISOL_N<=1, done<=1, bit counter<=0, state -> IDLE. ccff_head holds its last value.
- Bit counter width is $clog2(CHAIN_LEN+1). It never exceeds CHAIN_LEN, and no word is accepted after the CHAIN_LEN-th.
- start outside IDLE is ignored.
- bs_valid outside LOAD is ignored; no word is consumed.
- bs_valid low in LOAD: wait indefinitely (unless watchdog). prog_clk stays 0.
- start and reset in the same cycle: reset wins.
- Reset mid-load: next cycle all outputs return to reset values. The fabric is left partially configured, with no undo, and a new start reloads from bit 0.
- pReset and config_enable never toggle in the same cycle as prog_clk rises.

Optional Feature:
- CCFF_LOAD_WATCHDOG_EN defined:
  - A stall counter runs in LOAD, cleared on each handshake and on entry to LOAD.
  - On reaching TIMEOUT_CYCLES with no handshake: err<=1, config_enable<=0, IO_ISOL_N stays 0 (fabric kept isolated), prog_clk=0, state -> IDLE, done stays 0.
  - err clears on the next accepted start or reset.
- Not defined: no stall counter; err tied 0; LOAD waits forever.

Test Plan:
- Reset: assert reset 2 cycles mid-PRESET -> next cycle pReset=1, config_enable=0, IO_ISOL_N=1, busy=0, prog_clk=0, ccff_head=0.
- Full load, NUM_CHAINS=12, CHAIN_LEN=4, PRESET_CYCLES=2, bs_valid always 1, words 0xA5A,0x5A5,0xFFF,0x001:
  - pReset low exactly 2 cycles.
  - 4 prog_clk pulses, each 1 cycle high, 3 cycles apart.
  - ccff_head equals each word at the corresponding prog_clk rise.
  - done=1 and IO_ISOL_N=1 one cycle after the last PULSE.
- Backpressure: deassert bs_valid for 10 cycles after word 2 -> bs_ready stays 1, prog_clk stays 0, ccff_head holds 0x5A5; load completes with exactly 4 pulses.
- start pulsed during LOAD and bs_valid pulsed during SETUP/PULSE -> no restart, no extra word consumed, pulse count still 4.
- Reload: second start after done -> done drops the same cycle PRESET is entered, and a second 4-word load completes correctly.
- With CCFF_LOAD_WATCHDOG_EN, TIMEOUT_CYCLES=16, stall after word 1 -> err=1 at cycle 16 of stall, state IDLE, IO_ISOL_N=0, done=0; a new start clears err.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// Streams a NUM_CHAINS-wide bitstream into the fabric configuration chains and sequences pReset/config_enable/IO_ISOL_N.
// Optional stall watchdog enabled by defining CCFF_LOAD_WATCHDOG_EN.
module ccff_bitstream_loader #(
  parameter int unsigned NUM_CHAINS     = 12,
  parameter int unsigned CHAIN_LEN      = 1024,
  parameter int unsigned PRESET_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_CHAINS-1:0] bs_data,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  output logic                  prog_clk,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  pReset,
  output logic                  config_enable,
  output logic                  IO_ISOL_N,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CNT_W   = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PCNT_W  = $clog2(PRESET_CYCLES + 1);
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESET, S_LOAD, S_SETUP, S_PULSE, S_FINISH
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [PCNT_W-1:0]     r_preset_cnt;
  logic                  r_prog_clk;
  logic [NUM_CHAINS-1:0] r_head;
  logic                  r_preset_n;
  logic                  r_cfg_en;
  logic                  r_iso_n;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_hs;

  if (PRESET_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("PRESET_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  assign bs_ready      = (r_state == S_LOAD);
  assign w_hs          = bs_valid && (r_state == S_LOAD);
  assign prog_clk      = r_prog_clk;
  assign ccff_head     = r_head;
  assign pReset        = r_preset_n;
  assign config_enable = r_cfg_en;
  assign IO_ISOL_N     = r_iso_n;
  assign busy          = r_busy;
  assign done          = r_done;

`ifdef CCFF_LOAD_WATCHDOG_EN
  logic [STALL_W-1:0] r_stall;
  logic               r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Load sequencer: each word takes LOAD -> SETUP (data setup) -> PULSE (prog_clk high)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_preset_cnt <= '0;
      r_prog_clk   <= 1'b0;
      r_head       <= '0;
      r_preset_n   <= 1'b1;
      r_cfg_en     <= 1'b0;
      r_iso_n      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef CCFF_LOAD_WATCHDOG_EN
      r_stall      <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_PRESET;
            r_preset_n   <= 1'b0;
            r_cfg_en     <= 1'b1;
            r_iso_n      <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_preset_cnt <= '0;
            r_bit_cnt    <= '0;
`ifdef CCFF_LOAD_WATCHDOG_EN
            r_err        <= 1'b0;
`endif
          end
        end
        S_PRESET: begin
          if (r_preset_cnt == PCNT_W'(PRESET_CYCLES - 1)) begin
            r_preset_n <= 1'b1;
            r_state    <= S_LOAD;
`ifdef CCFF_LOAD_WATCHDOG_EN
            r_stall    <= '0;
`endif
          end else begin
            r_preset_cnt <= r_preset_cnt + PCNT_W'(1);
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            r_head    <= bs_data;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_state   <= S_SETUP;
`ifdef CCFF_LOAD_WATCHDOG_EN
            r_stall   <= '0;
          end else if (r_stall == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            // Abort keeps the fabric isolated; done stays low
            r_err     <= 1'b1;
            r_cfg_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_stall   <= r_stall + STALL_W'(1);
`endif
          end
        end
        S_SETUP: begin
          r_prog_clk <= 1'b1;
          r_state    <= S_PULSE;
        end
        S_PULSE: begin
          r_prog_clk <= 1'b0;
          if (r_bit_cnt == CNT_W'(CHAIN_LEN)) begin
            r_state <= S_FINISH;
          end else begin
            r_state <= S_LOAD;
`ifdef CCFF_LOAD_WATCHDOG_EN
            r_stall <= '0;
`endif
          end
        end
        S_FINISH: begin
          r_cfg_en  <= 1'b0;
          r_iso_n   <= 1'b1;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_bit_cnt <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Randomized bench for ccff_bitstream_loader; expectations come from the load protocol rules
// (pulse count, word order, pulse spacing, sequencing of globals), not from the RTL states.
module tb_ccff_bitstream_loader;

  localparam int unsigned NC = 12;
  localparam int unsigned CL = 4;
  localparam int unsigned PC = 2;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NC-1:0] bs_data;
  logic          bs_valid;
  logic          bs_ready;
  logic          prog_clk;
  logic [NC-1:0] ccff_head;
  logic          pReset;
  logic          config_enable;
  logic          IO_ISOL_N;
  logic          busy;
  logic          done;
  logic          err;

  logic [NC-1:0] words [CL];
  int n_total = 0;
  int n_bad   = 0;

  ccff_bitstream_loader #(
    .NUM_CHAINS(NC), .CHAIN_LEN(CL), .PRESET_CYCLES(PC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bs_data(bs_data), .bs_valid(bs_valid),
    .bs_ready(bs_ready), .prog_clk(prog_clk), .ccff_head(ccff_head), .pReset(pReset),
    .config_enable(config_enable), .IO_ISOL_N(IO_ISOL_N), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 time unit after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset_values(input string pfx);
    check({pfx, "_bs_ready"}, bs_ready, 0);
    check({pfx, "_prog_clk"}, prog_clk, 0);
    check({pfx, "_head"}, ccff_head, 0);
    check({pfx, "_preset_n"}, pReset, 1);
    check({pfx, "_cfg_en"}, config_enable, 0);
    check({pfx, "_iso_n"}, IO_ISOL_N, 1);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_err"}, err, 0);
  endtask

  // One complete load of words[]; optional stall after stall_after words, optional stray start in LOAD
  task automatic run_load(input int stall_after, input int stall_len, input bit poke_start);
    int  idx = 0, pulses = 0, preset_low = 0, stalled = 0, stall_since = 0;
    int  last_rise = -1, cyc = 0, wide = 0;
    bit  prev_pclk = 0, prev_preset, prev_cfg, poked = 0, hs;
    bs_valid = 1'b1;
    bs_data  = words[0];
    start    = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    check("start_preset_n", pReset, 0);
    check("start_cfg_en", config_enable, 1);
    check("start_iso_n", IO_ISOL_N, 0);
    check("start_done", done, 0);
    check("start_busy", busy, 1);
    check("preset_bs_ready", bs_ready, 0);
    preset_low  = (pReset == 1'b0) ? 1 : 0;
    prev_preset = pReset;
    prev_cfg    = config_enable;
    while (!done && cyc < 500) begin
      bs_valid = !(idx == stall_after && stalled < stall_len);
      bs_data  = words[(idx < CL) ? idx : CL - 1];
      start    = poke_start && !poked && bs_ready && pulses == 1;
      if (start) poked = 1;
      hs = bs_valid && bs_ready;
      if (bs_ready && !bs_valid) begin
        stalled++;
        stall_since++;
        check("stall_prog_clk", prog_clk, 0);
        if (idx > 0) check("stall_head_hold", ccff_head, words[idx-1]);
      end
      step();
      cyc++;
      start = 1'b0;
      if (hs) idx++;
      if (!pReset) preset_low++;
      if (prog_clk && prev_pclk) wide++;
      if (prog_clk && !prev_pclk) begin
        if (pulses < CL) check($sformatf("head_at_rise%0d", pulses), ccff_head, words[pulses]);
        else check("pulse_overrun", pulses, CL - 1);
        check("rise_globals_stable", {pReset, config_enable, prev_preset, prev_cfg}, 4'hF);
        if (last_rise >= 0) check("rise_gap", cyc - last_rise, 3 + stall_since);
        last_rise   = cyc;
        stall_since = 0;
        pulses++;
      end
      prev_pclk   = prog_clk;
      prev_preset = pReset;
      prev_cfg    = config_enable;
    end
    check("done_seen", done, 1);
    check("done_latency", cyc - last_rise, 2);
    check("pulse_count", pulses, CL);
    check("words_used", idx, CL);
    check("preset_low_cycles", preset_low, PC);
    check("pclk_wide_cycles", wide, 0);
    check("end_iso_n", IO_ISOL_N, 1);
    check("end_cfg_en", config_enable, 0);
    check("end_busy", busy, 0);
    check("end_preset_n", pReset, 1);
    check("end_err", err, 0);
    check("end_head", ccff_head, words[CL-1]);
    step();
    check("idle_done_hold", done, 1);
    check("idle_bs_ready", bs_ready, 0);
    check("idle_head_hold", ccff_head, words[CL-1]);
    bs_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    bs_valid = 1'b0;
    bs_data  = '0;
    repeat (3) step();
    reset = 1'b0;
    check_idle_reset_values("por");

    // Reset held two cycles in the middle of PRESET
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("mid_preset_preset_n", pReset, 0);
    reset = 1'b1;
    step();
    check_idle_reset_values("rst_mid_preset");
    step();
    reset = 1'b0;
    step();
    check("post_rst_busy", busy, 0);

    // Reset wins over a simultaneous start
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_preset_n", pReset, 1);
    step();
    check("rst_start_idle", busy, 0);

    words[0] = 12'hA5A; words[1] = 12'h5A5; words[2] = 12'hFFF; words[3] = 12'h001;
    run_load(CL, 0, 1'b0);
    run_load(2, 10, 1'b0);
    run_load(CL, 0, 1'b1);

    // Reset mid-load, then a fresh load from bit 0
    for (int i = 0; i < CL; i++) words[i] = NC'($urandom);
    bs_valid = 1'b1;
    bs_data  = words[0];
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_reset_values("rst_mid_load");
    for (int i = 0; i < CL; i++) words[i] = NC'($urandom);
    run_load(CL, 0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < CL; i++) words[i] = NC'($urandom);
      run_load(int'($urandom_range(0, CL - 1)), int'($urandom_range(0, 12)), 1'($urandom));
    end

`ifdef CCFF_LOAD_WATCHDOG_EN
    begin
      int n = 0, cnt = 0;
      for (int i = 0; i < CL; i++) words[i] = NC'($urandom);
      bs_valid = 1'b1;
      bs_data  = words[0];
      start    = 1'b1;
      step();
      start = 1'b0;
      while (!bs_ready && n < 20) begin step(); n++; end
      step();
      bs_valid = 1'b0;
      n = 0;
      while (!err && n < 100) begin
        if (bs_ready) cnt++;
        step();
        n++;
      end
      check("wd_err", err, 1);
      check("wd_stall_cycles", cnt, TO);
      check("wd_busy", busy, 0);
      check("wd_iso_n", IO_ISOL_N, 0);
      check("wd_done", done, 0);
      check("wd_cfg_en", config_enable, 0);
      check("wd_prog_clk", prog_clk, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("wd_err_clear", err, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
